// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I load/store
// funct3 encodings, the LSU state type and a funct3 legality helper.
package mem_stage_lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Stores only exist in signed-agnostic byte/half/word form; the unsigned
  // variants are load-only.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic write);
    logic ok;
    ok = 1'b0;
    case (f3)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Word-wide data-memory bus with a single-cycle req/ack handshake.
// The LSU is the master; the memory (or a bench model) is the slave.
interface mem_stage_lsu_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Purely combinational lane logic for the LSU: store byte enables and lane
// replication, legality/alignment checks, and load-data extraction with
// sign or zero extension.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request side: size from funct3[1:0], lanes from the low address bits.
  always_comb begin
    o_illegal    = !funct3_legal(i_funct3, i_write);
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_misaligned = i_addr_lo[0];
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      default: o_misaligned = |i_addr_lo;
    endcase
    if (!i_write) o_wdata = '0;
  end

  // Response side: pick the addressed lane, then extend per funct3.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_lane)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct3)
      LS_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      LS_BU:   o_ldata = {24'h0, w_byte};
      LS_H:    o_ldata = {{16{w_half[15]}}, w_half};
      LS_HU:   o_ldata = {16'h0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Accepts one load/store from EX/MEM, stalls the
// pipeline while it runs a byte-enabled word access on the data bus, and
// returns extended load data plus an error flag with a one-cycle done pulse.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req_valid_i,
  input  logic          req_write_i,
  input  logic [2:0]    req_funct3_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          stall_o,
  output logic          done_o,
  output logic [31:0]   rdata_o,
  output logic          misaligned_o,
  output logic          illegal_o,
  output logic          bus_err_o,
  mem_stage_lsu_if.master bus
);

  localparam bit                   LP_TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lane;
  logic                 r_done;
  logic [31:0]          r_rdata;
  logic                 r_misaligned;
  logic                 r_illegal;
  logic                 r_bus_err;
  logic                 r_bus_req;
  logic                 r_bus_we;
  logic [31:0]          r_bus_addr;
  logic [3:0]           r_bus_be;
  logic [31:0]          r_bus_wdata;

  logic                 w_illegal;
  logic                 w_misaligned;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_ldata;

  mem_stage_lsu_align u_align (
    .i_write      (req_write_i),
    .i_funct3     (req_funct3_i),
    .i_addr_lo    (req_addr_i[1:0]),
    .i_wdata      (req_wdata_i),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_lane    (r_lane),
    .i_rdata      (bus.bus_rdata_i),
    .o_ldata      (w_ldata)
  );

  // Stall is combinational so the request cycle itself already freezes the
  // front of the pipe; it is forced low while reset is held.
  assign stall_o = RESET & (((r_state == IDLE) & req_valid_i) | (r_state == BUSY));

  assign done_o           = r_done;
  assign rdata_o          = r_rdata;
  assign misaligned_o     = r_misaligned;
  assign illegal_o        = r_illegal;
  assign bus_err_o        = r_bus_err;
  assign bus.bus_req_o    = r_bus_req;
  assign bus.bus_we_o     = r_bus_we;
  assign bus.bus_addr_o   = r_bus_addr;
  assign bus.bus_be_o     = r_bus_be;
  assign bus.bus_wdata_o  = r_bus_wdata;

  // Control FSM: accept/check request, run the bus access, report completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_funct3     <= '0;
      r_lane       <= '0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= '0;
      r_bus_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_write  <= req_write_i;
            r_funct3 <= req_funct3_i;
            r_lane   <= req_addr_i[1:0];
            // Errors are reported without touching the bus; illegal wins.
            if (w_illegal) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_illegal <= 1'b1;
            end else if (w_misaligned) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_state     <= BUSY;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= req_write_i;
              r_bus_addr  <= {req_addr_i[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          // An ack arriving on the expiry cycle still completes normally.
          if (bus.bus_ack_i) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_rdata     <= r_write ? 32'h0 : w_ldata;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
          end else if (LP_TO_EN && (r_cnt == LP_CNT_LAST)) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_bus_err   <= 1'b1;
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          // The instruction retires this cycle; req_valid_i still shows it.
          r_state      <= IDLE;
          r_done       <= 1'b0;
          r_rdata      <= '0;
          r_misaligned <= 1'b0;
          r_illegal    <= 1'b0;
          r_bus_err    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized loads/stores
// against a behavioural model, including timeouts and reset mid-access.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        stall_o, done_o, misaligned_o, illegal_o, bus_err_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_write_i  (req_write_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .illegal_o    (illegal_o),
    .bus_err_o    (bus_err_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.bus_ack_i   = 1'b0;
    bus.bus_rdata_i = 32'h0;
  end

  typedef struct packed {
    int          stall_cyc;
    int          req_cyc;
    int          done_cnt;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        unstable;
    logic [31:0] rdata;
    logic        ill;
    logic        mis;
    logic        err;
    logic        bad_done;
    logic        stray;
  } obs_t;

  typedef struct packed {
    int          stall;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
    logic        mis;
    logic        err;
  } exp_t;

  function automatic logic [106:0] all_outs();
    return {stall_o, done_o, rdata_o, misaligned_o, illegal_o, bus_err_o,
            bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_be_o, bus.bus_wdata_o};
  endfunction

  // Reference: what one access must look like, derived from the RV32I rules.
  // ack_at = BUSY cycle (1-based) in which memory acks; 0 = never.
  function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int ack_at, input logic [31:0] rword);
    exp_t e;
    int lane, size, busy;
    logic [31:0] v;
    e = '0;
    lane = int'(a[1:0]);
    size = int'(f3[1:0]);
    if (f3 == 3'd3 || f3 >= 3'd6 || (w && f3 >= 3'd4)) begin
      e.ill = 1'b1; e.stall = 1; return e;
    end
    if ((size == 1 && a[0]) || (size == 2 && lane != 0)) begin
      e.mis = 1'b1; e.stall = 1; return e;
    end
    e.we   = w;
    e.addr = a - 32'(lane);
    if (size == 0)      e.be = 4'(1 << lane);
    else if (size == 1) e.be = (lane >= 2) ? 4'hC : 4'h3;
    else                e.be = 4'hF;
    if (w) begin
      if (size == 0)      e.wdata = {24'h0, wd[7:0]} * 32'h01010101;
      else if (size == 1) e.wdata = {16'h0, wd[15:0]} * 32'h00010001;
      else                e.wdata = wd;
    end
    if (ack_at >= 1 && ack_at <= TO) busy = ack_at;
    else begin busy = TO; e.err = 1'b1; end
    e.stall = 1 + busy;
    if (!w && !e.err) begin
      v = rword >> (8 * lane);
      if (size == 0) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v - 32'd256;
      end else if (size == 1) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v - 32'd65536;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // Drives one request (held until done) and plays the memory side.
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rword,
                         output obs_t o);
    int busy_idx;
    o = '0;
    busy_idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      req_valid_i = 1'b1; req_write_i = w; req_funct3_i = f3;
      req_addr_i = a; req_wdata_i = wd;
      bus.bus_ack_i = 1'b0;
      bus.bus_rdata_i = $urandom;
      #1;
      if (bus.bus_req_o) begin
        busy_idx++;
        if (busy_idx == 1) begin
          o.we = bus.bus_we_o; o.addr = bus.bus_addr_o;
          o.be = bus.bus_be_o; o.wdata = bus.bus_wdata_o;
        end else if ({o.we, o.addr, o.be, o.wdata} !==
                     {bus.bus_we_o, bus.bus_addr_o, bus.bus_be_o, bus.bus_wdata_o}) begin
          o.unstable = 1'b1;
        end
        if (busy_idx == ack_at) begin
          bus.bus_ack_i = 1'b1;
          bus.bus_rdata_i = rword;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.bus_ack_i = 1'b1;
      end
      if (stall_o) o.stall_cyc++;
      if (done_o) begin
        o.done_cnt++;
        o.rdata = rdata_o; o.ill = illegal_o; o.mis = misaligned_o; o.err = bus_err_o;
        if (stall_o || bus.bus_req_o) o.bad_done = 1'b1;
        break;
      end else if (misaligned_o || illegal_o || bus_err_o || rdata_o != 32'h0) begin
        o.stray = 1'b1;
      end
    end
    o.req_cyc = busy_idx;
    bus.bus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_release_idle: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      bus.bus_ack_i = 1'b1;
      bus.bus_rdata_i = $urandom;
      #1;
      checks++;
      if (all_outs() !== '0) begin
        errors++; $display("FAIL idle_outputs: got %h expected 0", all_outs());
      end
    end
    bus.bus_ack_i = 1'b0;
  endtask

  task automatic test_store();
    obs_t o;
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0, o);
    checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_bus: got %h expected %h", {o.we, o.addr, o.be, o.wdata},
                         {1'b1, 32'h100, 4'hF, 32'hDEADBEEF});
    end
    checks++;
    if (o.stall_cyc != 3 || o.done_cnt != 1 || o.req_cyc != 2) begin
      errors++; $display("FAIL sw_timing: got stall=%0d done=%0d req=%0d expected 3 1 2",
                         o.stall_cyc, o.done_cnt, o.req_cyc);
    end
    run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0, o);
    checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sb_bus: got %h expected %h", {o.we, o.addr, o.be, o.wdata},
                         {1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5});
    end
    checks++;
    if (o.rdata !== 32'h0 || {o.ill, o.mis, o.err} !== 3'b000) begin
      errors++; $display("FAIL sb_result: got rdata=%h flags=%b expected 0 000", o.rdata, {o.ill, o.mis, o.err});
    end
  endtask

  task automatic test_load_ext();
    obs_t o;
    run_txn(1'b0, 3'b000, 32'h202, 32'hFFFFFFFF, 1, 32'h12807F34, o);
    checks++;
    if (o.rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_rdata: got %h expected %h", o.rdata, 32'hFFFFFF80);
    end
    checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b0, 32'h200, 4'b0100, 32'h0}) begin
      errors++; $display("FAIL lb_bus: got %h expected %h", {o.we, o.addr, o.be, o.wdata},
                         {1'b0, 32'h200, 4'b0100, 32'h0});
    end
    run_txn(1'b0, 3'b100, 32'h202, 32'h0, 1, 32'h12807F34, o);
    checks++;
    if (o.rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_rdata: got %h expected %h", o.rdata, 32'h00000080);
    end
    run_txn(1'b0, 3'b101, 32'h202, 32'h0, 3, 32'h12807F34, o);
    checks++;
    if (o.rdata !== 32'h00001280 || o.be !== 4'b1100) begin
      errors++; $display("FAIL lhu_rdata: got %h/%b expected 00001280/1100", o.rdata, o.be);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h105, 32'h0, 1, 32'h0, o);
    checks++;
    if (o.req_cyc != 0 || o.stall_cyc != 1 || o.done_cnt != 1) begin
      errors++; $display("FAIL lw_mis_timing: got req=%0d stall=%0d done=%0d expected 0 1 1",
                         o.req_cyc, o.stall_cyc, o.done_cnt);
    end
    checks++;
    if ({o.ill, o.mis, o.err} !== 3'b010 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL lw_mis_flags: got %b/%h expected 010/0", {o.ill, o.mis, o.err}, o.rdata);
    end
    run_txn(1'b0, 3'b011, 32'h105, 32'h0, 1, 32'h0, o);
    checks++;
    if ({o.ill, o.mis, o.err} !== 3'b100 || o.req_cyc != 0) begin
      errors++; $display("FAIL ld_illegal: got %b req=%0d expected 100 req=0", {o.ill, o.mis, o.err}, o.req_cyc);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0, o);
    checks++;
    if (o.req_cyc != TO || {o.ill, o.mis, o.err} !== 3'b001 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL timeout: got req=%0d flags=%b rdata=%h expected %0d 001 0",
                         o.req_cyc, {o.ill, o.mis, o.err}, o.rdata, TO);
    end
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, TO, 32'hCAFEF00D, o);
    checks++;
    if (o.req_cyc != TO || {o.ill, o.mis, o.err} !== 3'b000 || o.rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ack_at_expiry: got req=%0d flags=%b rdata=%h expected %0d 000 cafef00d",
                         o.req_cyc, {o.ill, o.mis, o.err}, o.rdata, TO);
    end
  endtask

  task automatic test_reset_busy();
    obs_t o;
    logic [31:0] rw;
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h400;
    @(negedge clk);
    #1;
    checks++;
    if (bus.bus_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre: got bus_req=%b expected 1", bus.bus_req_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bus_req_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL rst_busy_drop: got req/stall=%b expected 00", {bus.bus_req_o, stall_o});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done_o !== 1'b0) begin
        errors++; $display("FAIL rst_busy_nodone: got done=%b expected 0", done_o);
      end
    end
    req_valid_i = 1'b0;
    rst_n = 1'b1;
    rw = $urandom;
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 1, rw, o);
    checks++;
    if (o.rdata !== rw || o.done_cnt != 1 || o.stall_cyc != 2) begin
      errors++; $display("FAIL rst_recover: got rdata=%h done=%0d stall=%0d expected %h 1 2",
                         o.rdata, o.done_cnt, o.stall_cyc, rw);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic w;
    logic [2:0] f3;
    logic [31:0] a, wd, rw;
    int ack_at;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      wd = $urandom;
      rw = $urandom;
      ack_at = $urandom_range(0, TO + 1);
      e = model(w, f3, a, wd, ack_at, rw);
      run_txn(w, f3, a, wd, ack_at, rw, o);
      checks++;
      if (o.done_cnt != 1 || o.stall_cyc != e.stall || o.req_cyc != e.stall - 1) begin
        errors++; $display("FAIL rnd_timing[%0d]: got done=%0d stall=%0d req=%0d expected 1 %0d %0d",
                           n, o.done_cnt, o.stall_cyc, o.req_cyc, e.stall, e.stall - 1);
      end
      checks++;
      if ({o.ill, o.mis, o.err, o.rdata} !== {e.ill, e.mis, e.err, e.rdata}) begin
        errors++; $display("FAIL rnd_result[%0d]: got %b/%h expected %b/%h", n,
                           {o.ill, o.mis, o.err}, o.rdata, {e.ill, e.mis, e.err}, e.rdata);
      end
      if (o.req_cyc > 0) begin
        checks++;
        if ({o.we, o.addr, o.be, o.wdata, o.unstable} !== {e.we, e.addr, e.be, e.wdata, 1'b0}) begin
          errors++; $display("FAIL rnd_bus[%0d]: got %h expected %h", n,
                             {o.we, o.addr, o.be, o.wdata, o.unstable}, {e.we, e.addr, e.be, e.wdata, 1'b0});
        end
      end
      checks++;
      if ({o.bad_done, o.stray} !== 2'b00) begin
        errors++; $display("FAIL rnd_hygiene[%0d]: got %b expected 00", n, {o.bad_done, o.stray});
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
          errors++; $display("FAIL rnd_gap[%0d]: got %h expected 0", n, all_outs());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_store();
    test_load_ext();
    test_errors();
    test_timeout();
    test_reset_busy();
    test_random();
    @(negedge clk);
    req_valid_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
